univ_shift_reg: RTL and testbench

Parametrised universal register: a WIDTH-bit register with asynchronous reset, synchronous clear/set, and eight selectable operations (hold, load, shifts, rotates, increment, decrement). It also provides a registered carry/borrow flag and a zero flag. It is the general-purpose storage/sequencing element for datapaths that previously chained single-bit set/reset flip-flops, and is instantiated wherever a register, shift chain or small counter is needed.

---
 rtl/univ_shift_reg_pkg.sv | 22 ++
 rtl/univ_shift_reg_if.sv | 28 ++
 rtl/univ_shift_reg_next_state.sv | 66 ++++++
 rtl/univ_shift_reg.sv | 55 +++++
 tb/tb_univ_shift_reg.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and the legal-width check used by every block that decodes op.
package univ_shift_reg_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  // True when a register width is inside the supported range.
  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
// There is no handshake: every rising edge with en high consumes one
// operation, and q/carry/zero are always valid.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic             sclr;
  logic             sset;
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             zero;

  // Driver side: issues operations, observes the register.
  modport master (
    output sclr, sset, en, op, d, sin,
    input  q, carry, zero
  );

  // Register side.
  modport slave (
    input  sclr, sset, en, op, d, sin,
    output q, carry, zero
  );
endinterface

// File: rtl/univ_shift_reg_next_state.sv
// Purely combinational next-state computation for one enabled operation.
// Arithmetic is done WIDTH+1 bits wide so the extra MSB is carry/borrow.
module usr_next_state
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_carry_next
);

  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  assign w_inc = {1'b0, i_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, i_q} - {{WIDTH{1'b0}}, 1'b1};

  // Decode op into the new register value and its flag.
  always_comb begin
    o_q_next     = i_q;
    o_carry_next = 1'b0;
    case (i_op)
      OP_HOLD: begin
        o_q_next     = i_q;
        o_carry_next = 1'b0;  // unused: the top keeps carry on HOLD
      end
      OP_LOAD: begin
        o_q_next     = i_d;
        o_carry_next = 1'b0;
      end
      OP_SHL: begin
        o_q_next     = {i_q[WIDTH-2:0], i_sin};
        o_carry_next = i_q[WIDTH-1];
      end
      OP_SHR: begin
        o_q_next     = {i_sin, i_q[WIDTH-1:1]};
        o_carry_next = i_q[0];
      end
      OP_ROL: begin
        o_q_next     = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_carry_next = i_q[WIDTH-1];
      end
      OP_ROR: begin
        o_q_next     = {i_q[0], i_q[WIDTH-1:1]};
        o_carry_next = i_q[0];
      end
      OP_INC: begin
        o_q_next     = w_inc[WIDTH-1:0];
        o_carry_next = w_inc[WIDTH];
      end
      OP_DEC: begin
        o_q_next     = w_dec[WIDTH-1:0];
        o_carry_next = w_dec[WIDTH];
      end
      default: begin
        o_q_next     = i_q;
        o_carry_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: state flops, clear/set/enable priority and the
// zero flag. The per-operation datapath lives in usr_next_state.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  univ_shift_reg_if.slave  bus
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("univ_shift_reg: WIDTH must be within 2..64");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH-1:0] w_q_next;
  logic             w_carry_next;

  usr_next_state #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_q          (r_q),
    .i_op         (bus.op),
    .i_d          (bus.d),
    .i_sin        (bus.sin),
    .o_q_next     (w_q_next),
    .o_carry_next (w_carry_next)
  );

  // State update: async reset, then sclr > sset > enabled op > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= RESET_VAL;
      r_carry <= 1'b0;
    end else if (bus.sclr) begin
      r_q     <= '0;
      r_carry <= 1'b0;
    end else if (bus.sset) begin
      r_q     <= '1;
      r_carry <= 1'b0;
    end else if (bus.en && (bus.op != OP_HOLD)) begin
      r_q     <= w_q_next;
      r_carry <= w_carry_next;
    end
  end

  assign bus.q     = r_q;
  assign bus.carry = r_carry;
  assign bus.zero  = (r_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, RESET_VAL=A5): directed scenarios plus
// random operations, scored against an integer-arithmetic reference model.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int         W   = 8;
  localparam int         MOD = 256;
  localparam logic [7:0] RV  = 8'hA5;
  localparam int         EW  = W + 2;  // {carry, zero, q}

  logic clk;
  logic rst;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            carry_pulses = 0;

  // Reference model: register value as a plain integer.
  int m_q;
  int m_c;

  function automatic logic [EW-1:0] pack_exp(input int qv, input int cv);
    logic [EW-1:0] r;
    r[W-1:0] = qv[W-1:0];
    r[W]     = (qv == 0);
    r[W+1]   = cv[0];
    return r;
  endfunction

  // Applies one clock edge's worth of inputs to the model.
  function automatic void model_step(input bit sc, input bit ss, input bit en,
                                     input int op, input int dv, input bit si);
    int sv;
    sv = si ? 1 : 0;
    if (sc) begin
      m_q = 0; m_c = 0;
    end else if (ss) begin
      m_q = MOD - 1; m_c = 0;
    end else if (en) begin
      case (op)
        0: ;
        1: begin m_q = dv; m_c = 0; end
        2: begin m_c = (m_q >= MOD/2); m_q = (m_q * 2 + sv) % MOD; end
        3: begin m_c = m_q % 2; m_q = m_q / 2 + sv * (MOD/2); end
        4: begin m_c = (m_q >= MOD/2); m_q = (m_q * 2) % MOD + m_q / (MOD/2); end
        5: begin m_c = m_q % 2; m_q = m_q / 2 + (m_q % 2) * (MOD/2); end
        6: begin m_c = (m_q == MOD - 1); m_q = (m_q + 1) % MOD; end
        default: begin m_c = (m_q == 0); m_q = (m_q + MOD - 1) % MOD; end
      endcase
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Drive inputs, let one rising edge consume them, queue the expectation.
  task automatic step(input bit sc, input bit ss, input bit en, input int op,
                      input int dv, input bit si, input string nm);
    bus.sclr = sc;
    bus.sset = ss;
    bus.en   = en;
    bus.op   = op[2:0];
    bus.d    = dv[W-1:0];
    bus.sin  = si;
    @(posedge clk);
    model_step(sc, ss, en, op, dv, si);
    exp_q.push_back(pack_exp(m_q, m_c));
    name_q.push_back(nm);
    #1;
  endtask

  task automatic op1(input int op, input int dv, input bit si, input string nm);
    step(1'b0, 1'b0, 1'b1, op, dv, si, nm);
  endtask

  // Compare the DUT now against constants taken from the scenario text.
  task automatic check_now(input string nm, input logic [7:0] eq, input bit ec, input bit ez);
    n_cmp++;
    if (bus.q !== eq || bus.carry !== ec || bus.zero !== ez) begin
      n_bad++;
      $display("FAIL %s: got q=%h carry=%b zero=%b, want q=%h carry=%b zero=%b",
               nm, bus.q, bus.carry, bus.zero, eq, ec, ez);
    end
  endtask

  // Check after the monitor has drained this edge's expectation.
  task automatic check_after(input string nm, input logic [7:0] eq, input bit ec, input bit ez);
    @(negedge clk);
    #1;
    check_now(nm, eq, ec, ez);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic async_reset_pulse(input string nm);
    @(negedge clk);
    #2;
    rst = 1'b1;
    m_q = RV; m_c = 0;
    #1;
    check_now(nm, RV, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      string         nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.carry, bus.zero, bus.q};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got carry=%b zero=%b q=%h, want carry=%b zero=%b q=%h",
                 nm, a[W+1], a[W], a[W-1:0], e[W+1], e[W], e[W-1:0]);
      end
      if (nm == "inc256" && bus.carry === 1'b1) carry_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    bus.sclr = 1'b0;
    bus.sset = 1'b0;
    bus.en   = 1'b0;
    bus.op   = OP_HOLD;
    bus.d    = '0;
    bus.sin  = 1'b0;
    m_q = RV; m_c = 0;

    #3;
    check_now("reset_value", RV, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset / hold
    op1(0, 0, 0, "hold_after_reset");
    check_after("hold_a5", RV, 1'b0, 1'b0);
    op1(1, 8'h3C, 0, "load_3c");
    async_reset_pulse("async_reset");

    // Load and shift
    op1(1, 8'h81, 0, "load_81");
    op1(2, 0, 1, "shl");
    check_after("shl_03", 8'h03, 1'b1, 1'b0);
    op1(3, 0, 0, "shr");
    check_after("shr_01", 8'h01, 1'b1, 1'b0);

    // Rotate
    op1(1, 8'h80, 0, "load_80");
    op1(4, 0, 0, "rol");
    check_after("rol_01", 8'h01, 1'b1, 1'b0);
    op1(5, 0, 0, "ror");
    check_after("ror_80", 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) op1(4, 0, 0, "rol8");
    check_after("rol8_80", 8'h80, 1'b0, 1'b0);

    // Counter wrap
    op1(1, 8'hFE, 0, "load_fe");
    op1(6, 0, 0, "inc");
    check_after("inc_ff", 8'hFF, 1'b0, 1'b0);
    op1(6, 0, 0, "inc");
    check_after("inc_wrap", 8'h00, 1'b1, 1'b1);
    op1(7, 0, 0, "dec");
    check_after("dec_wrap", 8'hFF, 1'b1, 1'b0);

    // Priority
    step(1'b1, 1'b1, 1'b1, 1, 8'h3C, 0, "sclr_sset_load");
    check_after("prio_clear", 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, "sset");
    check_after("sset_ff", 8'hFF, 1'b0, 1'b0);

    // Enable low ignores op
    op1(1, 8'h42, 0, "load_42");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 6, $urandom_range(0, 255), 1, "en_low");
    check_after("en_low_hold", 8'h42, 1'b0, 1'b0);

    // Reset in the middle of counting, then resume from A5
    op1(1, 8'h10, 0, "load_10");
    op1(6, 0, 0, "inc_pre");
    op1(6, 0, 0, "inc_pre");
    async_reset_pulse("reset_mid_inc");
    op1(6, 0, 0, "inc_post");
    check_after("resume_a6", 8'hA6, 1'b0, 1'b0);
    op1(6, 0, 0, "inc_post");

    // Full INC period: back to start with exactly one carry pulse
    op1(1, 8'h37, 0, "load_37");
    for (int i = 0; i < MOD; i++) op1(6, 0, 0, "inc256");
    check_after("inc256_start", 8'h37, 1'b0, 1'b0);
    n_cmp++;
    if (carry_pulses != 1) begin
      n_bad++;
      $display("FAIL inc256_pulses: got %0d carry pulses, want 1", carry_pulses);
    end

    // Random operations with occasional clear/set and async resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7),
           $urandom_range(0, 255), $urandom_range(0, 1) == 1, "random");
      if ($urandom_range(0, 39) == 0) async_reset_pulse("random_reset");
    end

    // Drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
